fft_frame_loader: RTL
=====================

// Module: fft_frame_loader
// PURPOSE
//   Upstream stage of the FFT block. Accepts a stream of real samples on a valid/ready handshake.
//   Packs every N_POINTS consecutive samples into one frame, using two ping-pong banks.
//   Presents each completed frame on frame_r and drives the FFT start/done handshake.
//   frame_r feeds FFT xr; fft_start feeds FFT start; FFT done returns on fft_done.
//   One bank fills while the other bank is being transformed.
// PARAMETERS
//   SAMPLE_W  32  width of one real sample, in bits
//   N_POINTS  4   samples per frame; frame width is N_POINTS*SAMPLE_W (default 128)
// PORTS
//   clk         in   1                  single clock, rising edge
//   rst         in   1                  asynchronous, active-high reset
//   s_valid     in   1                  upstream sample valid
//   s_data      in   SAMPLE_W           upstream sample
//   s_ready     out  1                  loader can accept a sample this cycle
//   frame_r     out  N_POINTS*SAMPLE_W  frame to FFT; sample k at [k*SAMPLE_W +: SAMPLE_W]
//   fft_start   out  1                  level start request to FFT
//   fft_done    in   1                  FFT completion flag (level or pulse)
//   busy        out  1                  high while state != IDLE
//   frame_cnt   out  16                 frames completed by the FFT; wraps 0xFFFF -> 0
// BEHAVIOUR
//   Reset (async, rst=1): clears bank_full[1:0], fill_bank, launch_bank, wr_idx, state=IDLE.
//     Also clears frame_r, fft_start, frame_cnt and busy to 0. s_ready=1 once rst falls.
//     A partial frame is discarded. fft_start drops immediately, without waiting for clk.
//   Fill side:
//     s_ready = !bank_full[fill_bank] (combinational).
//     A sample is accepted on an edge where s_valid && s_ready.
//     The sample is written to bank[fill_bank][wr_idx], then wr_idx increments.
//     When wr_idx == N_POINTS-1 is accepted: wr_idx -> 0, bank_full[fill_bank] set, fill_bank toggles.
//     If the new fill bank is still full, s_ready stays low until that bank is freed (no drops).
//   Launch FSM:
//     IDLE:    if bank_full[launch_bank] -> RUN.
//              On the same edge: frame_r <= bank[launch_bank]; fft_start <= 1.
//     RUN:     fft_start=1; frame_r held stable.
//              On fft_done=1 -> RELEASE, with fft_start <= 0, bank_full[launch_bank] cleared,
//              launch_bank toggles, and frame_cnt += 1.
//     RELEASE: fft_start=0; wait for fft_done=0 -> IDLE.
//              This guarantees start is low >=1 cycle and done has dropped before the next launch.
//   Latency: fft_start rises on the edge after the one accepting the frame's last sample (1 cycle).
//     In steady state, back-to-back frames need one IDLE cycle after RELEASE.
//   Ordering: frames launch in exactly the order they were filled (banks alternate 0,1,0,...).
//   Simultaneous events:
//     Bank freed in RUN on the same edge another bank completes: both updates take effect.
//     Freed bank becomes fillable (s_ready=1) the next cycle.
//     Sample accepted on the same edge as a free: the free only affects launch_bank's bank.
//       The write goes to fill_bank, so there is no conflict.
//   fft_done high while in IDLE: ignored.
//   Rollover: frame_cnt 0xFFFF + 1 -> 0x0000.
// TESTING
//   1. Reset, then push 1,2,3,4 with s_valid held.
//      -> fft_start=1 on the next edge; frame_r = {32'd4,32'd3,32'd2,32'd1}; busy=1.
//   2. Hold fft_done=0 and push 8 more samples 5..12.
//      -> 5..8 fill bank1; s_ready=0 after sample 8; samples 9..12 stall.
//      Then pulse fft_done -> frame_r={8,7,6,5} launches; s_ready=1 one cycle after the free.
//   3. fft_done held high 5 cycles.
//      -> fft_start low the cycle after done rises; no relaunch until done=0; frame_cnt=1.
//   4. Assert rst mid-frame after 2 samples.
//      -> fft_start, busy, frame_r, frame_cnt = 0 asynchronously; next 4 samples form a fresh frame.
//   5. Stream 20 frames with a model FFT, done 3 cycles after start; upstream random valid.
//      -> every frame matches its input samples in order; frame_cnt=20; no sample lost or duplicated.
//   6. Preload frame_cnt to 0xFFFF via 65535 frames (or force), complete one more frame.
//      -> frame_cnt=0x0000.

Source files
------------

// File: rtl/fft_frame_loader.sv
// rtl/fft_frame_loader.sv - ping-pong sample-to-frame packer driving the FFT start/done handshake
// One bank fills from the sample stream while the other is held on frame_r for the FFT.
module fft_frame_loader #(
  parameter int SAMPLE_W = 32,
  parameter int N_POINTS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  input  logic [SAMPLE_W-1:0]          s_data,
  output logic                         s_ready,
  output logic [N_POINTS*SAMPLE_W-1:0] frame_r,
  output logic                         fft_start,
  input  logic                         fft_done,
  output logic                         busy,
  output logic [15:0]                  frame_cnt
);

  localparam int FRAME_W = N_POINTS * SAMPLE_W;
  localparam int IDX_W   = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  typedef enum logic [1:0] {IDLE, RUN, RELEASE} state_t;

  state_t              r_state;
  logic [1:0]          r_bank_full;
  logic                r_fill_bank;
  logic                r_launch_bank;
  logic [IDX_W-1:0]    r_wr_idx;
  logic [SAMPLE_W-1:0] r_bank [2][N_POINTS];
  logic [FRAME_W-1:0]  r_frame;
  logic                r_fft_start;
  logic                r_busy;
  logic [15:0]         r_frame_cnt;

  logic                w_accept;
  logic                w_last;
  logic                w_free;
  logic [1:0]          w_set;
  logic [1:0]          w_clr;
  logic [FRAME_W-1:0]  w_launch_frame;

  assign s_ready   = !r_bank_full[r_fill_bank];
  assign w_accept  = s_valid && s_ready;
  assign w_last    = w_accept && (r_wr_idx == LAST_IDX);
  assign w_free    = (r_state == RUN) && fft_done;
  assign w_set     = {w_last && r_fill_bank, w_last && !r_fill_bank};
  assign w_clr     = {w_free && r_launch_bank, w_free && !r_launch_bank};

  assign frame_r   = r_frame;
  assign fft_start = r_fft_start;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;

  always_comb begin
    w_launch_frame = '0;
    for (int k = 0; k < N_POINTS; k++) begin
      w_launch_frame[k*SAMPLE_W +: SAMPLE_W] = r_bank[r_launch_bank][k];
    end
  end

  // Sample storage needs no reset: a bank is only read once its full flag is set.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_bank[r_fill_bank][r_wr_idx] <= s_data;
    end
  end

  // Fill and free always target different banks, so set and clear never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank_full <= 2'b00;
      r_fill_bank <= 1'b0;
      r_wr_idx    <= '0;
    end else begin
      r_bank_full <= (r_bank_full & ~w_clr) | w_set;
      if (w_accept) begin
        if (w_last) begin
          r_wr_idx    <= '0;
          r_fill_bank <= !r_fill_bank;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_launch_bank <= 1'b0;
      r_frame       <= '0;
      r_fft_start   <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_cnt   <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_bank_full[r_launch_bank]) begin
            r_state     <= RUN;
            r_frame     <= w_launch_frame;
            r_fft_start <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        RUN: begin
          if (fft_done) begin
            r_state       <= RELEASE;
            r_fft_start   <= 1'b0;
            r_launch_bank <= !r_launch_bank;
            r_frame_cnt   <= r_frame_cnt + 16'd1;
          end
        end
        RELEASE: begin
          // Holding here until done drops keeps a level-style done from relaunching.
          if (!fft_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_fft_start <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
